multi_train_fault_monitor: RTL and testbench

- Per-train fault monitor for the multi-train reservation datapath.
- Checks every train channel's booked-seat count and fare against configurable limits.
- Debounces faults with a persistence filter and self-heals after a run of clean samples.
- Feeds the recovery/steering logic: per-channel fault flags, fault causes, healing status, and a global saturating fault-event counter.

---
 rtl/multi_train_fault_monitor.sv | 208 ++++++++++++++++++++
 tb/tb_multi_train_fault_monitor.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_train_fault_monitor.sv
// Per-train fault monitor: classifies each channel's booked-seat count and fare,
// debounces faults (OK/SUSPECT/FAULT/HEALING) and counts new fault episodes.
module multi_train_fault_monitor #(
  parameter int N_TRAINS  = 4,
  parameter int CNT_W     = 4,
  parameter int FARE_W    = 10,
  parameter int MAX_SEATS = 9,
  parameter int MAX_FARE  = 900,
  parameter int PERSIST   = 2,
  parameter int HEAL      = 4,
  parameter int EVT_W     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_TRAINS-1:0]        sample_valid,
  input  logic [N_TRAINS*CNT_W-1:0]  booked_count,
  input  logic [N_TRAINS*FARE_W-1:0] fare,
  input  logic [N_TRAINS-1:0]        fault_clr,
  output logic [N_TRAINS-1:0]        fault_flag,
  output logic [N_TRAINS-1:0]        healing,
  output logic [2*N_TRAINS-1:0]      fault_cause,
  output logic                       any_fault,
  output logic [EVT_W-1:0]           fault_events
);

  localparam int MAX_PH = (PERSIST > HEAL) ? PERSIST : HEAL;
  localparam int CW     = $clog2(MAX_PH + 1);
  localparam int NW     = $clog2(N_TRAINS + 1);
  localparam int SUM_W  = EVT_W + NW;

  localparam logic [CW-1:0]    PERSIST_C = CW'(PERSIST);
  localparam logic [CW-1:0]    HEAL_C    = CW'(HEAL);
  localparam logic [31:0]      SEAT_LIM  = 32'(MAX_SEATS);
  localparam logic [31:0]      FARE_LIM  = 32'(MAX_FARE);
  localparam logic [EVT_W-1:0] EVT_MAX   = '1;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_FAULT   = 2'd2,
    ST_HEALING = 2'd3
  } state_t;

  logic [N_TRAINS-1:0] entry_v;
  logic [N_TRAINS-1:0] flag_v;
  logic [N_TRAINS-1:0] heal_v;

  // sample_valid[i] qualifies channel i's count/fare for exactly this cycle; there is
  // no back-pressure, and an invalid cycle leaves that channel's state untouched.
  for (genvar i = 0; i < N_TRAINS; i++) begin : g_ch
    logic [CNT_W-1:0]  cnt_in;
    logic [FARE_W-1:0] fare_in;
    logic [1:0]        bits;
    logic              is_bad;
    logic              is_good;
    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
    logic [1:0]        cause_q, cause_d;
    logic              entry;
    logic              flag;
    logic              heal;

    assign cnt_in  = booked_count[i*CNT_W +: CNT_W];
    assign fare_in = fare[i*FARE_W +: FARE_W];
    assign bits    = {(32'(fare_in) > FARE_LIM), (32'(cnt_in) > SEAT_LIM)};
    assign is_bad  = sample_valid[i] & (|bits);
    assign is_good = sample_valid[i] & ~(|bits);
    assign cnt_inc = cnt_q + CW'(1);

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q <= ST_OK;
        cnt_q   <= '0;
        cause_q <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        cause_q <= cause_d;
      end
    end

    // Clear wins over any sample; entry marks OK/SUSPECT -> FAULT only, never relapses.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cause_d = cause_q;
      entry   = 1'b0;
      if (fault_clr[i]) begin
        state_d = ST_OK;
        cnt_d   = '0;
        cause_d = '0;
      end else begin
        unique case (state_q)
          ST_OK: begin
            if (is_bad) begin
              cause_d = bits;
              if (PERSIST == 1) begin
                state_d = ST_FAULT;
                cnt_d   = '0;
                entry   = 1'b1;
              end else begin
                state_d = ST_SUSPECT;
                cnt_d   = CW'(1);
              end
            end
          end
          ST_SUSPECT: begin
            if (is_bad) begin
              cause_d = cause_q | bits;
              if (cnt_inc == PERSIST_C) begin
                state_d = ST_FAULT;
                cnt_d   = '0;
                entry   = 1'b1;
              end else begin
                cnt_d = cnt_inc;
              end
            end else if (is_good) begin
              state_d = ST_OK;
              cnt_d   = '0;
              cause_d = '0;
            end
          end
          ST_FAULT: begin
            if (is_bad) begin
              cause_d = cause_q | bits;
            end else if (is_good) begin
              if (HEAL == 1) begin
                state_d = ST_OK;
                cnt_d   = '0;
                cause_d = '0;
              end else begin
                state_d = ST_HEALING;
                cnt_d   = CW'(1);
              end
            end
          end
          ST_HEALING: begin
            if (is_bad) begin
              state_d = ST_FAULT;
              cnt_d   = '0;
              cause_d = cause_q | bits;
            end else if (is_good) begin
              if (cnt_inc == HEAL_C) begin
                state_d = ST_OK;
                cnt_d   = '0;
                cause_d = '0;
              end else begin
                cnt_d = cnt_inc;
              end
            end
          end
          default: begin
            state_d = ST_OK;
            cnt_d   = '0;
            cause_d = '0;
          end
        endcase
      end
    end

    always_comb begin
      flag = 1'b0;
      heal = 1'b0;
      case (state_q)
        ST_FAULT:   flag = 1'b1;
        ST_HEALING: begin
          flag = 1'b1;
          heal = 1'b1;
        end
        default: begin
          flag = 1'b0;
          heal = 1'b0;
        end
      endcase
    end

    assign entry_v[i]         = entry;
    assign flag_v[i]          = flag;
    assign heal_v[i]          = heal;
    assign fault_cause[2*i +: 2] = cause_q;
  end

  assign fault_flag = flag_v;
  assign healing    = heal_v;
  assign any_fault  = |flag_v;

  logic [EVT_W-1:0] events_q, events_d;
  logic [NW-1:0]    n_entry;
  logic [SUM_W-1:0] evt_sum;

  // Simultaneous entries are summed in one cycle, then clamped at all-ones.
  always_comb begin
    n_entry = '0;
    for (int j = 0; j < N_TRAINS; j++) begin
      n_entry = n_entry + NW'(entry_v[j]);
    end
    evt_sum  = SUM_W'(events_q) + SUM_W'(n_entry);
    events_d = (evt_sum > SUM_W'(EVT_MAX)) ? EVT_MAX : evt_sum[EVT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) events_q <= '0;
    else      events_q <= events_d;
  end

  assign fault_events = events_q;

endmodule

// File: tb/tb_multi_train_fault_monitor.sv
// Bench for multi_train_fault_monitor: directed vector table, hand sequences for
// reset/gating/saturation, and random stimulus checked against a run-length model.
module tb_multi_train_fault_monitor;

  localparam int N         = 4;
  localparam int CNT_W     = 4;
  localparam int FARE_W    = 10;
  localparam int MAX_SEATS = 9;
  localparam int MAX_FARE  = 900;
  localparam int PERSIST   = 2;
  localparam int HEAL      = 4;

  logic              clk;
  logic              rst;
  logic [N-1:0]      sv;
  logic [N*CNT_W-1:0]  booked;
  logic [N*FARE_W-1:0] fare_in;
  logic [N-1:0]      clr;

  logic [N-1:0]   flag_a, heal_a, flag_b, heal_b;
  logic [2*N-1:0] cause_a, cause_b;
  logic           any_a, any_b;
  logic [7:0]     evt_a;
  logic [1:0]     evt_b;

  multi_train_fault_monitor dut_a (
    .clk(clk), .rst(rst), .sample_valid(sv), .booked_count(booked), .fare(fare_in),
    .fault_clr(clr), .fault_flag(flag_a), .healing(heal_a), .fault_cause(cause_a),
    .any_fault(any_a), .fault_events(evt_a)
  );

  multi_train_fault_monitor #(.EVT_W(2)) dut_b (
    .clk(clk), .rst(rst), .sample_valid(sv), .booked_count(booked), .fare(fare_in),
    .fault_clr(clr), .fault_flag(flag_b), .healing(heal_b), .fault_cause(cause_b),
    .any_fault(any_b), .fault_events(evt_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_cmp = 0;

  // reference model: each channel is either faulted or not, plus a run length
  bit         m_faulted[N];
  int         m_run[N];
  logic [1:0] m_cause[N];
  int         m_evt_a;
  int         m_evt_b;

  typedef struct {
    int ch; bit v; int cnt; int fare; bit clr;
    bit e_flag; bit e_heal; int e_cause; int e_evt;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_faulted[c] = 0;
      m_run[c]     = 0;
      m_cause[c]   = 2'b00;
    end
    m_evt_a = 0;
    m_evt_b = 0;
  endtask

  task automatic model_step();
    int ent;
    ent = 0;
    for (int c = 0; c < N; c++) begin
      int cv;
      int fv;
      logic [1:0] b;
      cv = int'(booked[c*CNT_W +: CNT_W]);
      fv = int'(fare_in[c*FARE_W +: FARE_W]);
      b  = {fv > MAX_FARE, cv > MAX_SEATS};
      if (clr[c]) begin
        m_faulted[c] = 0; m_run[c] = 0; m_cause[c] = 2'b00;
      end else if (sv[c]) begin
        if (!m_faulted[c]) begin
          if (b != 2'b00) begin
            m_cause[c] = (m_run[c] == 0) ? b : (m_cause[c] | b);
            m_run[c]++;
            if (m_run[c] >= PERSIST) begin
              m_faulted[c] = 1; m_run[c] = 0; ent++;
            end
          end else begin
            m_run[c] = 0; m_cause[c] = 2'b00;
          end
        end else begin
          if (b != 2'b00) begin
            m_cause[c] = m_cause[c] | b; m_run[c] = 0;
          end else begin
            m_run[c]++;
            if (m_run[c] >= HEAL) begin
              m_faulted[c] = 0; m_run[c] = 0; m_cause[c] = 2'b00;
            end
          end
        end
      end
    end
    m_evt_a = (m_evt_a + ent > 255) ? 255 : m_evt_a + ent;
    m_evt_b = (m_evt_b + ent > 3) ? 3 : m_evt_b + ent;
  endtask

  task automatic check_model();
    logic [N-1:0]   ef, eh;
    logic [2*N-1:0] ec;
    for (int c = 0; c < N; c++) begin
      ef[c] = m_faulted[c];
      eh[c] = m_faulted[c] && (m_run[c] > 0);
      ec[2*c +: 2] = m_cause[c];
    end
    chk("flag_a", 32'(flag_a), 32'(ef));
    chk("heal_a", 32'(heal_a), 32'(eh));
    chk("cause_a", 32'(cause_a), 32'(ec));
    chk("any_a", 32'(any_a), 32'(|ef));
    chk("evt_a", 32'(evt_a), 32'(m_evt_a));
    chk("flag_b", 32'(flag_b), 32'(ef));
    chk("heal_b", 32'(heal_b), 32'(eh));
    chk("cause_b", 32'(cause_b), 32'(ec));
    chk("any_b", 32'(any_b), 32'(|ef));
    chk("evt_b", 32'(evt_b), 32'(m_evt_b));
  endtask

  // driver: apply current inputs across one edge, then check against the model
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    n_vec++;
    check_model();
  endtask

  task automatic idle_inputs();
    sv      = '0;
    clr     = '0;
    booked  = {N{4'd5}};
    fare_in = {N{10'd500}};
  endtask

  task automatic set_ch(input int ch, input bit v, input int cnt, input int fr, input bit c);
    sv[ch] = v;
    booked[ch*CNT_W +: CNT_W]   = 4'(cnt);
    fare_in[ch*FARE_W +: FARE_W] = 10'(fr);
    clr[ch] = c;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_flag_a"}, 32'(flag_a), 0);
    chk({tag, "_heal_a"}, 32'(heal_a), 0);
    chk({tag, "_cause_a"}, 32'(cause_a), 0);
    chk({tag, "_any_a"}, 32'(any_a), 0);
    chk({tag, "_evt_a"}, 32'(evt_a), 0);
    chk({tag, "_flag_b"}, 32'(flag_b), 0);
    chk({tag, "_evt_b"}, 32'(evt_b), 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    #1;
    check_zero("rst");
    repeat (2) @(posedge clk);
    #1;
    check_zero("rst_hold");
    rst = 1'b1;
  endtask

  task automatic add(input int ch, input bit v, input int cnt, input int fr, input bit c,
                     input bit ef, input bit eh, input int ec, input int ee);
    vec_t t;
    t.ch = ch; t.v = v; t.cnt = cnt; t.fare = fr; t.clr = c;
    t.e_flag = ef; t.e_heal = eh; t.e_cause = ec; t.e_evt = ee;
    tbl.push_back(t);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    model_reset();
    #2;
    check_zero("por");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // reset mid-episode with channel 0 in FAULT
    idle_inputs();
    set_ch(0, 1, 12, 500, 0);
    step();
    step();
    chk("pre_rst_flag0", 32'(flag_a[0]), 1);
    #3;
    do_reset();
    idle_inputs();
    sv = '1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("idle_any", 32'(any_a), 0);
    end

    // directed table: {ch, valid, count, fare, clr} -> {flag, healing, cause, events}
    add(0, 1,  9, 900, 0, 0, 0, 0, 0);
    add(0, 1,  9, 901, 0, 0, 0, 2, 0);
    add(0, 1,  9, 900, 0, 0, 0, 0, 0);
    add(0, 1, 10, 900, 0, 0, 0, 1, 0);
    add(0, 1,  9, 900, 0, 0, 0, 0, 0);
    add(1, 1, 10, 500, 0, 0, 0, 1, 0);
    add(1, 1,  3, 500, 0, 0, 0, 0, 0);
    add(1, 1, 10, 500, 0, 0, 0, 1, 0);
    add(1, 1, 10, 500, 0, 1, 0, 1, 1);
    add(1, 0,  5, 500, 1, 0, 0, 0, 1);
    add(2, 1,  5, 950, 0, 0, 0, 2, 1);
    add(2, 1,  5, 950, 0, 1, 0, 2, 2);
    add(2, 1,  5, 500, 0, 1, 1, 2, 2);
    add(2, 1,  5, 500, 0, 1, 1, 2, 2);
    add(2, 1,  5, 500, 0, 1, 1, 2, 2);
    add(2, 1, 12, 500, 0, 1, 0, 3, 2);
    add(2, 1,  5, 500, 0, 1, 1, 3, 2);
    add(2, 1,  5, 500, 0, 1, 1, 3, 2);
    add(2, 1,  5, 500, 0, 1, 1, 3, 2);
    add(2, 1,  5, 500, 0, 0, 0, 0, 2);
    add(3, 1, 15, 500, 0, 0, 0, 1, 2);
    add(3, 1, 15, 500, 1, 0, 0, 0, 2);
    add(3, 1,  5, 1023, 0, 0, 0, 2, 2);
    add(3, 1,  5, 1023, 0, 1, 0, 2, 3);
    add(3, 0, 15, 500, 0, 1, 0, 2, 3);

    foreach (tbl[n]) begin
      idle_inputs();
      set_ch(tbl[n].ch, tbl[n].v, tbl[n].cnt, tbl[n].fare, tbl[n].clr);
      step();
      chk($sformatf("tbl%0d_flag", n), 32'(flag_a[tbl[n].ch]), 32'(tbl[n].e_flag));
      chk($sformatf("tbl%0d_heal", n), 32'(heal_a[tbl[n].ch]), 32'(tbl[n].e_heal));
      chk($sformatf("tbl%0d_cause", n), 32'(cause_a[tbl[n].ch*2 +: 2]), 32'(tbl[n].e_cause));
      chk($sformatf("tbl%0d_evt_a", n), 32'(evt_a), 32'(tbl[n].e_evt));
      chk($sformatf("tbl%0d_evt_b", n), 32'(evt_b), 32'(tbl[n].e_evt));
    end

    // channel 3 in FAULT, invalid samples for 20 cycles must not move it
    for (int k = 0; k < 20; k++) begin
      idle_inputs();
      set_ch(3, 0, (k % 2) ? 15 : 2, (k % 3) ? 1000 : 100, 0);
      step();
      chk("gate_flag3", 32'(flag_a[3]), 1);
      chk("gate_cause3", 32'(cause_a[7:6]), 2);
    end
    idle_inputs();
    set_ch(3, 0, 5, 500, 1);
    step();
    chk("clr3_flag", 32'(flag_a[3]), 0);
    chk("clr3_evt", 32'(evt_a), 3);

    // simultaneous entries on all channels, narrow counter saturates at 3
    do_reset();
    idle_inputs();
    sv = '1;
    booked = {N{4'd10}};
    step();
    step();
    chk("sim_flag", 32'(flag_a), 32'hF);
    chk("sim_evt_a", 32'(evt_a), 4);
    chk("sim_evt_b", 32'(evt_b), 3);
    idle_inputs();
    clr = '1;
    step();
    chk("sim_clr_flag", 32'(flag_a), 0);
    idle_inputs();
    sv = '1;
    booked = {N{4'd10}};
    step();
    step();
    chk("sim2_evt_a", 32'(evt_a), 8);
    chk("sim2_evt_b", 32'(evt_b), 3);

    // random stimulus, biased onto the limit boundaries
    for (int k = 0; k < 1500; k++) begin
      sv = 4'($urandom);
      for (int c = 0; c < N; c++) begin
        int r;
        r = $urandom_range(0, 3);
        booked[c*CNT_W +: CNT_W] = (r == 0) ? 4'd9 : (r == 1) ? 4'd10 : 4'($urandom_range(0, 15));
        r = $urandom_range(0, 3);
        fare_in[c*FARE_W +: FARE_W] = (r == 0) ? 10'd900 : (r == 1) ? 10'd901 : 10'($urandom_range(0, 1023));
        clr[c] = ($urandom_range(0, 19) == 0);
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
